regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with issue scoreboard.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned A0_IDX_DEF = 10;
  localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on writeback (issue wins),
// with NUM_RD combinational lookup ports and an OR-reduced busy_any.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_busy,
  output logic                     busy_any
);
  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Clear before set so a same-address issue overrides the writeback.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en && set_addr != ZERO_ADDR) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lk
    always_comb lk_busy[k] = busy[lk_addr[k*ADDR_W +: ADDR_W]];
  end

  always_comb busy_any = |busy;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and registered a0 mirror.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned A0_IDX = A0_IDX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DATA_W-1:0]        a0,
  output logic                     busy_any
);
  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] A0_ADDR   = ADDR_W'(A0_IDX);

  if (A0_IDX >= NREG) begin : g_bad_a0
    $error("regfile_sb: A0_IDX out of range for ADDR_W");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_nrd
    $error("regfile_sb: NUM_RD must be 1..4");
  end

  logic [DATA_W-1:0] mem [NREG];
  logic [NUM_RD-1:0] lk_busy;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .lk_addr  (rd_addr),
    .lk_busy  (lk_busy),
    .busy_any (busy_any)
  );

  // Register 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
      a0 <= '0;
    end else begin
      if (wr_en && wr_addr != ZERO_ADDR) mem[wr_addr] <= wr_data;
      a0 <= mem[A0_ADDR];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    always_comb ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    always_comb begin
      hit = wr_en && (wr_addr != ZERO_ADDR) && (wr_addr == ra);
      rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : mem[ra];
      rd_busy[k] = hit ? (iss_en && (iss_addr == wr_addr)) : lk_busy[k];
    end
`else
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = mem[ra];
      rd_busy[k] = lk_busy[k];
    end
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver pushes model expectations, monitor compares.
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic [DW-1:0]  a0;
  logic           busy_any;

  regfile_sb #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .A0_IDX(10)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .a0(a0), .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data [NR];
    logic          busy [NR];
    logic [DW-1:0] a0;
    logic          bany;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: architectural registers, busy flags and the a0 mirror.
  logic [DW-1:0] m_reg [32];
  logic          m_busy [32];
  logic [DW-1:0] m_a0;

  task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, c, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_a0 = '0;
  endtask

  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    exp_t e;
    logic [AW-1:0] ra [NR];
    @(negedge clk);
    rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
    rd_addr = {ra1, ra0};
    ra[0] = ra0; ra[1] = ra1;
    if (!r) model_clear();
    for (int k = 0; k < NR; k++) begin
      e.data[k] = m_reg[ra[k]];
      e.busy[k] = m_busy[ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && wa == ra[k]) begin
        e.data[k] = wd;
        e.busy[k] = ie && (ia == wa);
      end
`endif
    end
    e.a0 = m_a0;
    e.bany = 1'b0;
    for (int i = 0; i < 32; i++) e.bany = e.bany | m_busy[i];
    e.cyc = cyc;
    exp_q.push_back(e);
    cyc++;
    if (r) begin
      m_a0 = m_reg[10];
      if (we && wa != 0) m_reg[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (ie && ia != 0) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, ra0, ra1);
  endtask

  // Monitor: every cycle the DUT presents settled outputs a few ns after the driving edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NR; k++) begin
          chk($sformatf("rd_data%0d", k), e.cyc, rd_data[k*DW +: DW], e.data[k]);
          chk($sformatf("rd_busy%0d", k), e.cyc, {31'b0, rd_busy[k]}, {31'b0, e.busy[k]});
        end
        chk("a0", e.cyc, a0, e.a0);
        chk("busy_any", e.cyc, {31'b0, busy_any}, {31'b0, e.bany});
      end
    end
  end

  initial begin : driver
    logic [AW-1:0] wa, ia;
    int wait_cnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    model_clear();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd2, 5'd3);

    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
    step(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    idle(5'd0, 5'd5);

    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) idle(5'd7, 5'd7);
    step(1'b1, 1'b1, 5'd7, 32'h12, 1'b0, '0, 5'd7, 5'd1);
    idle(5'd7, 5'd7);

    step(1'b1, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd2);
    idle(5'd9, 5'd9);
    step(1'b1, 1'b1, 5'd9, 32'h56, 1'b1, 5'd4, 5'd9, 5'd4);
    idle(5'd9, 5'd4);
    step(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, '0, 5'd4, 5'd9);

    step(1'b1, 1'b1, 5'd10, 32'hA5A5, 1'b0, '0, 5'd10, 5'd0);
    idle(5'd10, 5'd10);
    idle(5'd10, 5'd10);

    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(1'b1, 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ia,
           ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0) ? ia : 5'($urandom_range(0, 31)));
    end

    step(1'b1, 1'b1, 5'd10, 32'h0BAD_F00D, 1'b0, '0, 5'd10, 5'd1);
    step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd3, 5'd10);
    idle(5'd3, 5'd10);
    // Reset asserted mid-cycle while a write and issue are presented.
    step(1'b0, 1'b1, 5'd3, 32'h77, 1'b1, 5'd6, 5'd6, 5'd10);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd6);
    idle(5'd3, 5'd6);
    idle(5'd3, 5'd10);
    idle(5'd10, 5'd3);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    #5;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
